// File: rtl/otter_intrpt_ctrl.sv
// otter_intrpt_ctrl: interrupt source block for the CSR unit.
// Provides the mtime/mtimecmp timer (MTIP), the software IRQ bit (MSIP), a
// synchronized external IRQ (MEIP) and level/edge custom IRQ lines on an MMIO bus.
// Optional build macro: OTTER_MTIME_SNAPSHOT_EN. When it is defined, a read of
// MTIME_LO latches mtime[63:32] into a shadow register, and MTIME_HI returns
// that shadow, so a LO-then-HI read pair is tear-free.
module otter_intrpt_ctrl #(
  parameter int unsigned PRESCALE   = 16,
  parameter int unsigned NUM_CUSTOM = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_rd,
  input  logic        bus_wr,
  input  logic [4:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_rvld,
  input  logic        ext_irq,
  input  logic [15:0] custom_irq,
  output logic [31:0] intrpt
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [15:0] CUSTOM_MASK = 16'((32'd1 << NUM_CUSTOM) - 32'd1);

  localparam logic [2:0] REG_MTIME_LO    = 3'd0;
  localparam logic [2:0] REG_MTIME_HI    = 3'd1;
  localparam logic [2:0] REG_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] REG_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] REG_MSIP        = 3'd4;
  localparam logic [2:0] REG_IRQ_EDGE    = 3'd5;
  localparam logic [2:0] REG_IRQ_PEND    = 3'd6;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic             msip_q, msip_d;
  logic [15:0]      edge_q, edge_d;
  logic [15:0]      pend_q, pend_d;
  logic [15:0]      prev_q;
  logic             sync1_q, sync2_q;
  logic [31:0]      intrpt_q, intrpt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvld_q;
  logic [31:0]      rd_val;

  logic [2:0]  reg_idx;
  logic        tick;
  logic [15:0] rise;
  logic [15:0] w1c;
  logic        unused_addr;

  assign reg_idx     = bus_addr[4:2];
  assign unused_addr = ^bus_addr[1:0];

`ifdef OTTER_MTIME_SNAPSHOT_EN
  logic [31:0] shadow_q, shadow_d;

  // Shadow of mtime[63:32] taken on every MTIME_LO read.
  always_comb begin
    shadow_d = shadow_q;
    if (bus_rd && (reg_idx == REG_MTIME_LO)) shadow_d = mtime_q[63:32];
  end

  // Shadow register.
  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end
`endif

  // Register file next-state: prescaler, timer, msip, edge config, pending bits.
  always_comb begin
    tick       = (cnt_q == CNT_MAX);
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    edge_d     = edge_q;
    w1c        = '0;

    // A write to either mtime half wins over the tick in that cycle.
    if (bus_wr && (reg_idx == REG_MTIME_LO))      mtime_d[31:0]  = bus_wdata;
    else if (bus_wr && (reg_idx == REG_MTIME_HI)) mtime_d[63:32] = bus_wdata;
    else if (tick)                                mtime_d        = mtime_q + 64'd1;

    if (bus_wr && (reg_idx == REG_MTIMECMP_LO)) mtimecmp_d[31:0]  = bus_wdata;
    if (bus_wr && (reg_idx == REG_MTIMECMP_HI)) mtimecmp_d[63:32] = bus_wdata;
    if (bus_wr && (reg_idx == REG_MSIP))        msip_d            = bus_wdata[0];
    if (bus_wr && (reg_idx == REG_IRQ_EDGE))    edge_d            = bus_wdata[15:0] & CUSTOM_MASK;
    if (bus_wr && (reg_idx == REG_IRQ_PEND))    w1c               = bus_wdata[15:0];

    // Rising edge sets pending; set beats a same-cycle clear.
    rise   = custom_irq & ~prev_q & edge_q & CUSTOM_MASK;
    pend_d = (pend_q & ~w1c) | rise;
  end

  // Interrupt vector next-state.
  always_comb begin
    intrpt_d        = '0;
    intrpt_d[3]     = msip_d;
    intrpt_d[7]     = (mtime_q >= mtimecmp_q);
    intrpt_d[11]    = sync2_q;
    intrpt_d[31:16] = ((edge_q & pend_d) | (~edge_q & custom_irq)) & CUSTOM_MASK;
  end

  // Read mux on current register values; a colliding write is not yet visible.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_MTIME_LO:    rd_val = mtime_q[31:0];
`ifdef OTTER_MTIME_SNAPSHOT_EN
      REG_MTIME_HI:    rd_val = shadow_q;
`else
      REG_MTIME_HI:    rd_val = mtime_q[63:32];
`endif
      REG_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      REG_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      REG_MSIP:        rd_val = {31'd0, msip_q};
      REG_IRQ_EDGE:    rd_val = {16'd0, edge_q};
      REG_IRQ_PEND:    rd_val = {16'd0, pend_q};
      default:         rd_val = '0;
    endcase
    rdata_d = bus_rd ? rd_val : rdata_q;
  end

  // State registers with synchronous reset taking priority over bus and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      edge_q     <= '0;
      pend_q     <= '0;
      prev_q     <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      intrpt_q   <= '0;
      rdata_q    <= '0;
      rvld_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      prev_q     <= custom_irq & CUSTOM_MASK;
      sync1_q    <= ext_irq;
      sync2_q    <= sync1_q;
      intrpt_q   <= intrpt_d;
      rdata_q    <= rdata_d;
      rvld_q     <= bus_rd;
    end
  end

  assign intrpt    = intrpt_q;
  assign bus_rdata = rdata_q;
  assign bus_rvld  = rvld_q;

endmodule

// File: tb/tb_otter_intrpt_ctrl.sv
// Directed bench for otter_intrpt_ctrl, built with PRESCALE=1 so mtime ticks every cycle.
module tb_otter_intrpt_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_rd = 1'b0;
  logic        bus_wr = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        bus_rvld;
  logic        ext_irq = 1'b0;
  logic [15:0] custom_irq = '0;
  logic [31:0] intrpt;

  int checks = 0;
  int errors = 0;

  otter_intrpt_ctrl #(.PRESCALE(1), .NUM_CUSTOM(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_rd     (bus_rd),
    .bus_wr     (bus_wr),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_rvld   (bus_rvld),
    .ext_irq    (ext_irq),
    .custom_irq (custom_irq),
    .intrpt     (intrpt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    bus_addr  = a;
    bus_wdata = d;
    bus_wr    = 1'b1;
    tick();
    bus_wr    = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d, output logic v);
    bus_addr = a;
    bus_rd   = 1'b1;
    tick();
    bus_rd   = 1'b0;
    d = bus_rdata;
    v = bus_rvld;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    rst = 1'b1;
    tick();
    tick();
    checks++; if (intrpt !== 32'h0) begin errors++; $display("FAIL reset_intrpt got %h exp %h", intrpt, 32'h0); end
    checks++; if (bus_rvld !== 1'b0) begin errors++; $display("FAIL reset_rvld got %b exp 0", bus_rvld); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus_rdata); end
    rst = 1'b0;
    repeat (10) tick();
    bus_read(5'h00, d, v);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL mtime_rvld got %b exp 1", v); end
    checks++; if (d !== 32'd10) begin errors++; $display("FAIL mtime_lo_10 got %0d exp 10", d); end
    checks++; if (intrpt !== 32'h0) begin errors++; $display("FAIL idle_intrpt got %h exp 0", intrpt); end
    bus_read(5'h08, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_lo_rst got %h exp ffffffff", d); end
    bus_read(5'h0C, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cmp_hi_rst got %h exp ffffffff", d); end
  endtask

  task automatic test_mtip();
    bus_write(5'h0C, 32'd0);
    bus_write(5'h00, 32'd0);
    bus_write(5'h08, 32'd20);
    repeat (19) tick();
    checks++; if (intrpt[7] !== 1'b0) begin errors++; $display("FAIL mtip_before got %b exp 0", intrpt[7]); end
    tick();
    checks++; if (intrpt[7] !== 1'b1) begin errors++; $display("FAIL mtip_at20 got %b exp 1", intrpt[7]); end
    bus_write(5'h08, 32'd1000);
    checks++; if (intrpt[7] !== 1'b1) begin errors++; $display("FAIL mtip_hold got %b exp 1", intrpt[7]); end
    tick();
    checks++; if (intrpt[7] !== 1'b0) begin errors++; $display("FAIL mtip_clear got %b exp 0", intrpt[7]); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        v;
    logic [31:0] exp_hi;
    bus_write(5'h04, 32'd0);
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_lo_pre got %h exp ffffffff", d); end
`ifdef OTTER_MTIME_SNAPSHOT_EN
    exp_hi = 32'd0;
`else
    exp_hi = 32'd1;
`endif
    bus_read(5'h04, d, v);
    checks++; if (d !== exp_hi) begin errors++; $display("FAIL wrap_hi got %h exp %h", d, exp_hi); end
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL wrap_lo_post got %h exp 1", d); end
    bus_read(5'h04, d, v);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL wrap_hi_post got %h exp 1", d); end
  endtask

  task automatic test_meip();
    ext_irq = 1'b1;
    tick();
    tick();
    checks++; if (intrpt[11] !== 1'b0) begin errors++; $display("FAIL meip_early got %b exp 0", intrpt[11]); end
    tick();
    checks++; if (intrpt[11] !== 1'b1) begin errors++; $display("FAIL meip_rise got %b exp 1", intrpt[11]); end
    ext_irq = 1'b0;
    tick();
    tick();
    checks++; if (intrpt[11] !== 1'b1) begin errors++; $display("FAIL meip_hold got %b exp 1", intrpt[11]); end
    tick();
    checks++; if (intrpt[11] !== 1'b0) begin errors++; $display("FAIL meip_fall got %b exp 0", intrpt[11]); end
  endtask

  task automatic test_custom();
    logic [31:0] d;
    logic        v;
    custom_irq[1] = 1'b1;
    tick();
    checks++; if (intrpt[17] !== 1'b1) begin errors++; $display("FAIL level_on got %b exp 1", intrpt[17]); end
    custom_irq[1] = 1'b0;
    tick();
    checks++; if (intrpt[17] !== 1'b0) begin errors++; $display("FAIL level_off got %b exp 0", intrpt[17]); end
    bus_write(5'h14, 32'h0001);
    custom_irq[0] = 1'b1;
    tick();
    checks++; if (intrpt[16] !== 1'b1) begin errors++; $display("FAIL edge_set got %b exp 1", intrpt[16]); end
    custom_irq[0] = 1'b0;
    tick();
    tick();
    checks++; if (intrpt[16] !== 1'b1) begin errors++; $display("FAIL edge_sticky got %b exp 1", intrpt[16]); end
    custom_irq[0] = 1'b1;
    bus_write(5'h18, 32'h0001);
    checks++; if (intrpt[16] !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", intrpt[16]); end
    bus_read(5'h18, d, v);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL pend_read got %h exp 1", d); end
    custom_irq[0] = 1'b0;
    bus_write(5'h18, 32'h0001);
    checks++; if (intrpt[16] !== 1'b0) begin errors++; $display("FAIL w1c_clear got %b exp 0", intrpt[16]); end
    bus_read(5'h18, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pend_cleared got %h exp 0", d); end
    bus_read(5'h14, d, v);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL edge_cfg got %h exp 1", d); end
  endtask

  task automatic test_msip_rst();
    logic [31:0] d;
    logic        v;
    bus_write(5'h10, 32'h1);
    checks++; if (intrpt[3] !== 1'b1) begin errors++; $display("FAIL msip_set got %b exp 1", intrpt[3]); end
    bus_addr  = 5'h10;
    bus_wdata = 32'h0;
    bus_wr    = 1'b1;
    bus_rd    = 1'b1;
    tick();
    bus_wr    = 1'b0;
    bus_rd    = 1'b0;
    checks++; if (bus_rdata !== 32'h1) begin errors++; $display("FAIL rdwr_old got %h exp 1", bus_rdata); end
    checks++; if (intrpt[3] !== 1'b0) begin errors++; $display("FAIL rdwr_commit got %b exp 0", intrpt[3]); end
    bus_read(5'h1C, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", d); end
    bus_write(5'h10, 32'h1);
    bus_addr = 5'h10;
    bus_rd   = 1'b1;
    rst      = 1'b1;
    tick();
    checks++; if (intrpt !== 32'h0) begin errors++; $display("FAIL rst_intrpt got %h exp 0", intrpt); end
    checks++; if (bus_rvld !== 1'b0) begin errors++; $display("FAIL rst_rvld got %b exp 0", bus_rvld); end
    checks++; if (bus_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus_rdata); end
    rst    = 1'b0;
    bus_rd = 1'b0;
    bus_read(5'h00, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mtime got %h exp 0", d); end
    bus_read(5'h08, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_lo got %h exp ffffffff", d); end
    bus_read(5'h0C, d, v);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi got %h exp ffffffff", d); end
    bus_read(5'h10, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_msip got %h exp 0", d); end
    checks++; if (intrpt !== 32'h0) begin errors++; $display("FAIL post_rst_intrpt got %h exp 0", intrpt); end
  endtask

  initial begin
    test_reset();
    test_mtip();
    test_wrap();
    test_meip();
    test_custom();
    test_msip_rst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
